// File: rtl/ssd_scan_scheduler.sv
// ---------------------------------------------------------------------------
// ssd_scan_scheduler
// Time-multiplexes an eight-digit seven-segment display. Each digit gets a
// blanking gap (all segments off) followed by a drive window. New display
// contents arrive over a valid/ready handshake into a pending buffer that is
// committed atomically to the active buffer at the frame boundary, so a
// frame never shows a mix of old and new data.
//
// Ports:
//   ClkPort      system clock
//   Reset        asynchronous, active-high reset
//   load_valid   requester offers new contents
//   load_data    eight hex nibbles, digit d = load_data[4d+3:4d]
//   load_mask    per-digit enable, 1 = lit
//   load_dp      per-digit decimal point, 1 = lit
//   load_ready   pending buffer empty (load accepted on valid && ready)
//   An           anodes, active-low, An[d] drives digit d
//   Cath         {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low
//   frame_start  one-cycle pulse on the first drive cycle of digit 0
// ---------------------------------------------------------------------------
module ssd_scan_scheduler #(
   parameter int unsigned DIGIT_CYCLES = 262144,
   parameter int unsigned BLANK_CYCLES = 1024
) (
   input  logic        ClkPort,
   input  logic        Reset,
   input  logic        load_valid,
   input  logic [31:0] load_data,
   input  logic [7:0]  load_mask,
   input  logic [7:0]  load_dp,
   output logic        load_ready,
   output logic [7:0]  An,
   output logic [7:0]  Cath,
   output logic        frame_start
);

   localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
   localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_DRIVE = 1'b1
   } state_t;

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  mask;
      logic [7:0]  dp;
   } disp_t;

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   disp_t            active_q, active_d;
   disp_t            pending_q, pending_d;
   logic             pending_full_q, pending_full_d;
   logic [7:0]       an_q, an_d;
   logic [7:0]       cath_q, cath_d;
   logic             frame_start_q, frame_start_d;

   logic             blank_done;
   logic             drive_done;
   logic             load_fire;
   logic [3:0]       nibble;

   // Hex digit to active-low abcdefg segments
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b0000001;
         4'h1:    s = 7'b1001111;
         4'h2:    s = 7'b0010010;
         4'h3:    s = 7'b0000110;
         4'h4:    s = 7'b1001100;
         4'h5:    s = 7'b0100100;
         4'h6:    s = 7'b0100000;
         4'h7:    s = 7'b0001111;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0000100;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b1100000;
         4'hC:    s = 7'b0110001;
         4'hD:    s = 7'b1000010;
         4'hE:    s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      return s;
   endfunction

   // Next-state, buffering and output computation
   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      cnt_d          = cnt_q;
      active_d       = active_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      an_d           = 8'hFF;
      cath_d         = 8'hFF;
      frame_start_d  = 1'b0;
      nibble         = 4'h0;

      blank_done = (state_q == S_BLANK) && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
      drive_done = (state_q == S_DRIVE) && (cnt_q == CNT_W'(DIGIT_CYCLES - 1));
      load_fire  = load_valid && !pending_full_q;

      // Commit and accept are mutually exclusive: accept needs pending empty
      if (blank_done && (idx_q == 3'd0) && pending_full_q) begin
         active_d       = pending_q;
         pending_full_d = 1'b0;
      end
      if (load_fire) begin
         pending_d      = '{data: load_data, mask: load_mask, dp: load_dp};
         pending_full_d = 1'b1;
      end

      if (blank_done) begin
         state_d       = S_DRIVE;
         cnt_d         = '0;
         frame_start_d = (idx_q == 3'd0);
      end else if (drive_done) begin
         state_d = S_BLANK;
         cnt_d   = '0;
         idx_d   = idx_q + 3'd1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      // Outputs follow the next state so they change on the transition edge
      nibble = active_d.data[{idx_d, 2'b00} +: 4];
      if ((state_d == S_DRIVE) && active_d.mask[idx_d]) begin
         an_d   = ~(8'(1) << idx_d);
         cath_d = {hex_seg(nibble), ~active_d.dp[idx_d]};
      end
   end

   // State and output registers
   always_ff @(posedge ClkPort or posedge Reset) begin
      if (Reset) begin
         state_q        <= S_BLANK;
         idx_q          <= 3'd0;
         cnt_q          <= '0;
         active_q       <= '0;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         an_q           <= 8'hFF;
         cath_q         <= 8'hFF;
         frame_start_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         cnt_q          <= cnt_d;
         active_q       <= active_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         an_q           <= an_d;
         cath_q         <= cath_d;
         frame_start_q  <= frame_start_d;
      end
   end

   assign load_ready  = ~pending_full_q;
   assign An          = an_q;
   assign Cath        = cath_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ssd_scan_scheduler
// Self-checking bench for ssd_scan_scheduler with DIGIT_CYCLES=8,
// BLANK_CYCLES=2. A reference model tracks cycles since reset release and
// derives the expected scan slot arithmetically (frame = 80 clocks, digit
// slot = 10 clocks, first 2 of each slot blank), plus the pending/active
// buffers of the load handshake.
// ---------------------------------------------------------------------------
module tb_ssd_scan_scheduler;

   localparam int unsigned DC    = 8;
   localparam int unsigned BC    = 2;
   localparam int unsigned SLOT  = DC + BC;
   localparam int unsigned FRAME = 8 * SLOT;

   logic        ClkPort = 1'b0;
   logic        Reset   = 1'b1;
   logic        load_valid = 1'b0;
   logic [31:0] load_data  = '0;
   logic [7:0]  load_mask  = '0;
   logic [7:0]  load_dp    = '0;
   logic        load_ready;
   logic [7:0]  An;
   logic [7:0]  Cath;
   logic        frame_start;

   int vectors    = 0;
   int miscompares = 0;

   // Reference model state
   int          m_cyc;
   logic [31:0] m_act_data, m_pend_data;
   logic [7:0]  m_act_mask, m_pend_mask;
   logic [7:0]  m_act_dp,   m_pend_dp;
   bit          m_pend_full;
   logic [6:0]  seg_tab [16];

   ssd_scan_scheduler #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
      .ClkPort     (ClkPort),
      .Reset       (Reset),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_mask   (load_mask),
      .load_dp     (load_dp),
      .load_ready  (load_ready),
      .An          (An),
      .Cath        (Cath),
      .frame_start (frame_start)
   );

   always #5 ClkPort = ~ClkPort;

   function automatic int cur_digit();
      return (m_cyc % FRAME) / SLOT;
   endfunction

   function automatic bit cur_lit();
      return ((m_cyc % SLOT) >= BC) && m_act_mask[cur_digit()];
   endfunction

   function automatic logic [7:0] exp_an();
      logic [7:0] a;
      a = 8'hFF;
      if (cur_lit()) a[cur_digit()] = 1'b0;
      return a;
   endfunction

   function automatic logic [7:0] exp_cath();
      int d;
      logic [3:0] n;
      d = cur_digit();
      n = 4'((m_act_data >> (4 * d)) & 32'hF);
      if (!cur_lit()) return 8'hFF;
      return {seg_tab[n], ~m_act_dp[d]};
   endfunction

   function automatic logic exp_fs();
      return (m_cyc % FRAME) == BC;
   endfunction

   function automatic logic [17:0] exp_all();
      return {exp_an(), exp_cath(), exp_fs(), ~m_pend_full};
   endfunction

   task automatic model_reset();
      m_cyc = 0;
      m_act_data = '0; m_act_mask = '0; m_act_dp = '0;
      m_pend_data = '0; m_pend_mask = '0; m_pend_dp = '0;
      m_pend_full = 1'b0;
   endtask

   // One clock: advances DUT and model together, returns whether a load fired
   task automatic step(output bit acc);
      bit pre_full, fire;
      logic [31:0] ld;
      logic [7:0]  lm, lp;
      pre_full = m_pend_full;
      fire = load_valid && !pre_full;
      ld = load_data; lm = load_mask; lp = load_dp;
      @(posedge ClkPort);
      m_cyc++;
      if ((m_cyc % FRAME) == BC && pre_full) begin
         m_act_data = m_pend_data; m_act_mask = m_pend_mask; m_act_dp = m_pend_dp;
         m_pend_full = 1'b0;
      end
      if (fire) begin
         m_pend_data = ld; m_pend_mask = lm; m_pend_dp = lp;
         m_pend_full = 1'b1;
      end
      #1;
      acc = fire;
   endtask

   task automatic offer(input logic [31:0] d, input logic [7:0] m, input logic [7:0] p);
      load_data = d; load_mask = m; load_dp = p; load_valid = 1'b1;
   endtask

   task automatic test_reset();
      int fs_at[$];
      bit acc;
      Reset = 1'b1;
      repeat (3) @(posedge ClkPort);
      #1;
      vectors++;
      if ({An, Cath, load_ready, frame_start} !== {8'hFF, 8'hFF, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_hold: got An=%h Cath=%h rdy=%b fs=%b, want FF FF 1 0", An, Cath, load_ready, frame_start);
      end
      Reset = 1'b0;
      model_reset();
      vectors++;
      if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
         miscompares++;
         $display("FAIL reset_cycle0: got %h want %h", {An, Cath, frame_start, load_ready}, exp_all());
      end
      for (int i = 0; i < 2 * FRAME + 5; i++) begin
         step(acc);
         if (frame_start === 1'b1) fs_at.push_back(m_cyc);
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL reset_scan cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
      end
      vectors++;
      if (fs_at.size() != 3 || fs_at[0] != 2 || fs_at[1] - fs_at[0] != 80) begin
         miscompares++;
         $display("FAIL frame_period: got %0d pulses first=%0d, want 3 pulses first=2 period=80",
                  fs_at.size(), (fs_at.size() > 0) ? fs_at[0] : -1);
      end
   endtask

   task automatic test_single_load();
      bit acc;
      int slot;
      offer(32'h8765_43F0, 8'hFF, 8'h01);
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(acc);
         if (acc) load_valid = 1'b0;
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL single_load cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
         slot = m_cyc % FRAME;
         if (m_act_data == 32'h8765_43F0) begin
            if (slot == 2 || slot == 12 || slot == 72) begin
               vectors++;
               if ((slot == 2  && {An, Cath} !== 16'hFE02) ||
                   (slot == 12 && {An, Cath} !== 16'hFD71) ||
                   (slot == 72 && {An, Cath} !== 16'h7F01)) begin
                  miscompares++;
                  $display("FAIL single_digit slot=%0d: got An=%h Cath=%h", slot, An, Cath);
               end
            end
            if ((slot % SLOT) < BC) begin
               vectors++;
               if ({An, Cath} !== 16'hFFFF) begin
                  miscompares++;
                  $display("FAIL single_blank slot=%0d: got An=%h Cath=%h want FF FF", slot, An, Cath);
               end
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit acc;
      int acc_cyc [$];
      logic [31:0] da, db;
      da = $urandom; db = $urandom;
      offer(da, 8'hFF, 8'($urandom));
      for (int i = 0; i < 3 * FRAME; i++) begin
         step(acc);
         if (acc) begin
            acc_cyc.push_back(m_cyc);
            if (acc_cyc.size() == 1) offer(db, 8'hFF, 8'($urandom));
            else load_valid = 1'b0;
         end
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL backpressure cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
      end
      vectors++;
      if (acc_cyc.size() != 2 || (acc_cyc[1] % FRAME) != BC + 1) begin
         miscompares++;
         $display("FAIL backpressure_accept: got %0d accepts, 2nd at slot %0d, want 2 accepts 2nd at slot 3",
                  acc_cyc.size(), (acc_cyc.size() > 1) ? acc_cyc[1] % FRAME : -1);
      end
   endtask

   task automatic test_masking();
      bit acc;
      offer($urandom, 8'b0000_0101, 8'($urandom));
      for (int i = 0; i < 2 * FRAME; i++) begin
         step(acc);
         if (acc) load_valid = 1'b0;
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL masking cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
         if (m_act_mask == 8'b0000_0101 && !(An === 8'hFF || An === 8'hFE || An === 8'hFB)) begin
            miscompares++;
            $display("FAIL masking_anode cyc=%0d: got An=%h want FF/FE/FB", m_cyc, An);
         end
      end
   endtask

   task automatic test_commit_race();
      bit acc;
      bit race_acc;
      logic [31:0] old_data;
      int guard;
      guard = 0;
      while (((m_cyc % FRAME) != BC - 1 || m_pend_full) && guard < 3 * FRAME) begin
         step(acc);
         guard++;
      end
      old_data = m_act_data;
      offer($urandom, 8'hFF, 8'($urandom));
      step(race_acc);
      load_valid = 1'b0;
      vectors++;
      if (!race_acc || m_act_data !== old_data || {An, Cath, frame_start, load_ready} !== exp_all()) begin
         miscompares++;
         $display("FAIL commit_race: got %h want %h (accepted=%b)", {An, Cath, frame_start, load_ready}, exp_all(), race_acc);
      end
      for (int i = 0; i < FRAME + 4; i++) begin
         step(acc);
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL commit_race_run cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
      end
   endtask

   task automatic test_mid_frame_reset();
      bit acc;
      int guard;
      offer($urandom, 8'hFF, 8'($urandom));
      guard = 0;
      while ((load_valid || m_pend_full) && guard < 3 * FRAME) begin
         step(acc);
         if (acc) load_valid = 1'b0;
         guard++;
      end
      offer($urandom, 8'hFF, 8'($urandom));
      guard = 0;
      while (((m_cyc % FRAME) != 4 * SLOT + 5 || load_valid) && guard < 3 * FRAME) begin
         step(acc);
         if (acc) load_valid = 1'b0;
         guard++;
      end
      vectors++;
      if (guard >= 3 * FRAME || {An, load_ready} !== {8'hEF, 1'b0}) begin
         miscompares++;
         $display("FAIL pre_reset: got An=%h rdy=%b want EF 0 (guard=%0d)", An, load_ready, guard);
      end
      #2 Reset = 1'b1;
      #1;
      vectors++;
      if ({An, Cath, load_ready, frame_start} !== {8'hFF, 8'hFF, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL async_reset: got An=%h Cath=%h rdy=%b fs=%b want FF FF 1 0", An, Cath, load_ready, frame_start);
      end
      @(posedge ClkPort);
      #1;
      Reset = 1'b0;
      model_reset();
      for (int i = 0; i < FRAME + 5; i++) begin
         step(acc);
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL post_reset cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
      end
   endtask

   task automatic test_random();
      bit acc;
      for (int i = 0; i < 8 * FRAME; i++) begin
         if (!load_valid && $urandom_range(0, 40) == 0)
            offer($urandom, 8'($urandom), 8'($urandom));
         step(acc);
         if (acc) load_valid = 1'b0;
         vectors++;
         if ({An, Cath, frame_start, load_ready} !== exp_all()) begin
            miscompares++;
            $display("FAIL random cyc=%0d: got %h want %h", m_cyc, {An, Cath, frame_start, load_ready}, exp_all());
         end
      end
   endtask

   initial begin
      seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                  7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                  7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                  7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
      model_reset();
      test_reset();
      test_single_load();
      test_backpressure();
      test_masking();
      test_commit_race();
      test_mid_frame_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
